pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter REG_AW, default 4, register-address width; the scoreboard holds 2**REG_AW entries.
REQ-002 SHALL have parameter HALT_OP, default 8'hFF, the opcode that requests halt.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port fetch_valid, input, 1, a fetched instruction word is available this cycle.
REQ-006 SHALL have port dec_opcode, input, 8, opcode of the instruction held in decode.
REQ-007 SHALL have ports dec_src_a and dec_src_b, input, REG_AW each, source register addresses in decode.
REQ-008 SHALL have port dec_dst, input, REG_AW, destination register address in decode.
REQ-009 SHALL have port dec_writes, input, 1, the decode instruction writes dec_dst.
REQ-010 SHALL have ports wb_valid, input, 1, and wb_dst, input, REG_AW, a writeback retiring a destination.
REQ-011 SHALL have port branch_taken, input, 1, execute resolved a taken branch.
REQ-012 SHALL have port resume, input, 1, single-cycle pulse to leave HALT.
REQ-013 SHALL have ports fetch_en, decode_en, exec_valid, stall, flush and halted, output, 1 each.
REQ-014 SHALL have ports stall_cnt and flush_cnt, output, 16 each, performance counters.

Function
REQ-015 SHALL implement FSM states RUN, FLUSH, HALT_DRAIN and HALTED.
REQ-016 dec_valid register SHALL load fetch_valid when fetch_en=1, clear on issue with no new fetch, and clear in FLUSH.
REQ-017 hazard SHALL be dec_valid AND (pending[src_a] OR pending[src_b] OR (dec_writes AND pending[dst])), using registered pending bits with no writeback bypass.
REQ-018 In RUN, stall SHALL equal hazard, fetch_en and decode_en SHALL equal !stall, and issue SHALL equal dec_valid AND !hazard.
REQ-019 Issue SHALL assert exec_valid on the next cycle for exactly one cycle, and SHALL set pending[dst] when dec_writes=1.
REQ-020 wb_valid SHALL clear pending[wb_dst]; if the same register is set by issue in the same cycle, set SHALL win.
REQ-021 branch_taken SHALL take priority over hazard and halt: the next state is FLUSH, and no issue occurs that cycle.
REQ-022 FLUSH SHALL last one cycle with flush=1, fetch_en=0, exec_valid=0 and dec_valid cleared, then return to RUN.
REQ-023 Issue of HALT_OP SHALL move the FSM to HALT_DRAIN; fetch_en=0 from the next cycle, and no further issue occurs.
REQ-024 HALT_DRAIN SHALL move to HALTED when all pending bits are zero, while wb_valid continues to clear pending bits.
REQ-025 HALTED SHALL assert halted=1 and move to RUN on resume; resume SHALL be ignored in every other state.
REQ-026 branch_taken received in HALT_DRAIN or HALTED SHALL be ignored.

Reset
REQ-027 rst SHALL immediately put the FSM in RUN and clear dec_valid, all pending bits, exec_valid, stall, flush, halted and both counters.
REQ-028 fetch_en and decode_en SHALL be 1 during and after reset.
REQ-029 Reset asserted mid-stall, mid-flush or mid-drain SHALL discard all in-flight state, with no exec_valid pulse after release.

Configuration
REQ-030 With macro PIPE_CTRL_PERF_EN defined: stall_cnt SHALL count cycles with stall=1 and flush_cnt SHALL count FLUSH entries; both saturate at 16'hFFFF.
REQ-031 Without PIPE_CTRL_PERF_EN: stall_cnt and flush_cnt SHALL be constant 0 and no counter registers SHALL exist.

Verification
REQ-032 Issue writer of r3, then reader of r3 with wb_valid of r3 two cycles later -> stall=1 for 3 cycles, then exec_valid=1 once.
REQ-033 Hazard stall with branch_taken=1 in the same cycle -> flush=1 for 1 cycle, dec_valid cleared, no exec_valid; with PIPE_CTRL_PERF_EN, flush_cnt=1.
REQ-034 Same-cycle issue writing r5 and wb_valid of r5 -> pending[5]=1 afterwards; a later reader of r5 stalls.
REQ-035 Issue HALT_OP with r1 pending -> HALT_DRAIN; halted=1 the cycle after wb of r1; resume -> RUN with fetch_en=1.
REQ-036 rst asserted during HALT_DRAIN with pending bits set -> FSM in RUN, pending=0, outputs at reset values within the same cycle.
REQ-037 With PIPE_CTRL_PERF_EN, 70000 forced stall cycles -> stall_cnt=16'hFFFF; without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/pipeline_control_if.sv
// Handshake bundle between the pipeline front end and pipeline_control.
// The master side drives fetch, decode, writeback and branch status; the slave side returns the pipeline controls.
interface pipeline_control_if #(
    parameter int REG_AW = 4
);
    logic              fetch_valid;
    logic [7:0]        dec_opcode;
    logic [REG_AW-1:0] dec_src_a;
    logic [REG_AW-1:0] dec_src_b;
    logic [REG_AW-1:0] dec_dst;
    logic              dec_writes;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_dst;
    logic              branch_taken;
    logic              resume;
    logic              fetch_en;
    logic              decode_en;
    logic              exec_valid;
    logic              stall;
    logic              flush;
    logic              halted;
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;

    modport master (
        output fetch_valid, dec_opcode, dec_src_a, dec_src_b, dec_dst, dec_writes,
        output wb_valid, wb_dst, branch_taken, resume,
        input  fetch_en, decode_en, exec_valid, stall, flush, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  fetch_valid, dec_opcode, dec_src_a, dec_src_b, dec_dst, dec_writes,
        input  wb_valid, wb_dst, branch_taken, resume,
        output fetch_en, decode_en, exec_valid, stall, flush, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_control.sv
// In-order pipeline controller: scoreboard hazard stall, taken-branch flush and halt/resume sequencing.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_control #(
    parameter int          REG_AW  = 4,
    parameter logic [7:0]  HALT_OP = 8'hFF
) (
    input logic               clk,
    input logic               rst,
    pipeline_control_if.slave bus
);
    localparam int NREG = 2 ** REG_AW;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALT_DRAIN,
        HALTED
    } state_e;

    state_e            state_q, state_d;
    logic              dec_valid_q, dec_valid_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic              exec_valid_q;
    logic              hazard;
    logic              stall;
    logic              issue;
    logic              fetch_en;

    // Hazard looks only at registered pending bits; a same-cycle writeback is not bypassed.
    assign hazard = dec_valid_q &&
                    (pending_q[bus.dec_src_a] || pending_q[bus.dec_src_b] ||
                     (bus.dec_writes && pending_q[bus.dec_dst]));

    assign stall    = (state_q == RUN) && hazard;
    assign fetch_en = (state_q == RUN) && !hazard;
    assign issue    = (state_q == RUN) && dec_valid_q && !hazard && !bus.branch_taken;

    // NOTE: every signal gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        dec_valid_d = dec_valid_q;
        pending_d   = pending_q;

        // Clear before set so an issue to the register being retired keeps it pending.
        if (bus.wb_valid) begin
            pending_d[bus.wb_dst] = 1'b0;
        end
        if (issue && bus.dec_writes) begin
            pending_d[bus.dec_dst] = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (bus.branch_taken) begin
                    state_d     = FLUSH;
                    dec_valid_d = 1'b0;
                end else begin
                    if (fetch_en) begin
                        dec_valid_d = bus.fetch_valid;
                    end
                    if (issue && (bus.dec_opcode == HALT_OP)) begin
                        state_d = HALT_DRAIN;
                    end
                end
            end
            FLUSH: begin
                dec_valid_d = 1'b0;
                state_d     = RUN;
            end
            HALT_DRAIN: begin
                // Looking at next-cycle pending lets the final writeback finish the drain.
                if (pending_d == '0) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (bus.resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            dec_valid_q  <= 1'b0;
            pending_q    <= '0;
            exec_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dec_valid_q  <= dec_valid_d;
            pending_q    <= pending_d;
            exec_valid_q <= issue;
        end
    end

    assign bus.fetch_en   = fetch_en;
    assign bus.decode_en  = fetch_en;
    assign bus.stall      = stall;
    assign bus.exec_valid = exec_valid_q;
    assign bus.flush      = (state_q == FLUSH);
    assign bus.halted     = (state_q == HALTED);

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        flush_entry;

    assign flush_entry = (state_d == FLUSH) && (state_q != FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush_entry && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = 16'h0000;
    assign bus.flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control; exec_valid expectations travel through a one-cycle scoreboard queue.
// Counter expectations follow PIPE_CTRL_PERF_EN, matching the build of the design.
module tb_pipeline_control;
    localparam logic [7:0] NOP  = 8'h01;
    localparam logic [7:0] HALT = 8'hFF;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic sb[$];

    pipeline_control_if #(.REG_AW(4)) bus ();

    pipeline_control #(.REG_AW(4), .HALT_OP(HALT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.fetch_valid  = 1'b0;
        bus.dec_opcode   = NOP;
        bus.dec_src_a    = '0;
        bus.dec_src_b    = '0;
        bus.dec_dst      = '0;
        bus.dec_writes   = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_dst       = '0;
        bus.branch_taken = 1'b0;
        bus.resume       = 1'b0;
    endtask

    task automatic set_dec(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] dst, input logic wr);
        bus.dec_opcode = op;
        bus.dec_src_a  = a;
        bus.dec_src_b  = b;
        bus.dec_dst    = dst;
        bus.dec_writes = wr;
    endtask

    // One clock of stimulus: compare this cycle's outputs, pop the exec_valid owed
    // by the previous cycle, and push whether this cycle should issue.
    task automatic cyc(input string tag, input logic e_stall, input logic e_fetch,
                       input logic e_flush, input logic e_halted, input logic e_issue);
        @(negedge clk);
        check({tag, ".stall"},    bus.stall,    e_stall);
        check({tag, ".fetch_en"}, bus.fetch_en, e_fetch);
        check({tag, ".flush"},    bus.flush,    e_flush);
        check({tag, ".halted"},   bus.halted,   e_halted);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s.sb observed=empty expected=entry", tag);
        end else begin
            check({tag, ".exec_valid"}, bus.exec_valid, sb.pop_front());
        end
        sb.push_back(e_issue);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_sb();
        sb.delete();
        sb.push_back(1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst.fetch_en",   bus.fetch_en,   1'b1);
        check("rst.decode_en",  bus.decode_en,  1'b1);
        check("rst.exec_valid", bus.exec_valid, 1'b0);
        check("rst.stall",      bus.stall,      1'b0);
        check("rst.flush",      bus.flush,      1'b0);
        check("rst.halted",     bus.halted,     1'b0);
        check("rst.stall_cnt",  bus.stall_cnt,  16'h0);
        check("rst.flush_cnt",  bus.flush_cnt,  16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_sb();

        // RAW on r3: three stall cycles, then exactly one issue
        bus.fetch_valid = 1'b1;
        cyc("a0", 0, 1, 0, 0, 0);
        set_dec(NOP, 4'd0, 4'd0, 4'd3, 1'b1);
        cyc("a1", 0, 1, 0, 0, 1);
        set_dec(NOP, 4'd3, 4'd0, 4'd4, 1'b1);
        bus.fetch_valid = 1'b0;
        cyc("a2", 1, 0, 0, 0, 0);
        check("a2.decode_en", bus.decode_en, 1'b0);
        cyc("a3", 1, 0, 0, 0, 0);
        bus.wb_valid = 1'b1;
        bus.wb_dst   = 4'd3;
        cyc("a4", 1, 0, 0, 0, 0);
        bus.wb_valid = 1'b0;
        cyc("a5", 0, 1, 0, 0, 1);
        bus.wb_valid = 1'b1;
        bus.wb_dst   = 4'd4;
        cyc("a6", 0, 1, 0, 0, 0);
        check("a.stall_cnt", bus.stall_cnt, PERF ? 16'd3 : 16'd0);
        bus.wb_valid = 1'b0;
        cyc("a7", 0, 1, 0, 0, 0);

        // Branch during a hazard stall: one flush cycle, decode emptied, no issue
        bus.fetch_valid = 1'b1;
        cyc("b0", 0, 1, 0, 0, 0);
        set_dec(NOP, 4'd0, 4'd0, 4'd6, 1'b1);
        cyc("b1", 0, 1, 0, 0, 1);
        set_dec(NOP, 4'd6, 4'd0, 4'd0, 1'b0);
        bus.fetch_valid  = 1'b0;
        bus.branch_taken = 1'b1;
        cyc("b2", 1, 0, 0, 0, 0);
        bus.branch_taken = 1'b0;
        bus.fetch_valid  = 1'b1;
        cyc("b3", 0, 0, 1, 0, 0);
        bus.fetch_valid = 1'b0;
        cyc("b4", 0, 1, 0, 0, 0);
        check("b.flush_cnt", bus.flush_cnt, PERF ? 16'd1 : 16'd0);
        bus.wb_valid = 1'b1;
        bus.wb_dst   = 4'd6;
        cyc("b5", 0, 1, 0, 0, 0);
        bus.wb_valid = 1'b0;

        // Same-cycle issue and writeback of r5: set wins, later reader stalls
        bus.fetch_valid = 1'b1;
        cyc("c0", 0, 1, 0, 0, 0);
        set_dec(NOP, 4'd0, 4'd0, 4'd5, 1'b1);
        bus.wb_valid = 1'b1;
        bus.wb_dst   = 4'd5;
        cyc("c1", 0, 1, 0, 0, 1);
        set_dec(NOP, 4'd0, 4'd5, 4'd0, 1'b0);
        bus.fetch_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        cyc("c2", 1, 0, 0, 0, 0);
        bus.wb_valid = 1'b1;
        cyc("c3", 1, 0, 0, 0, 0);
        bus.wb_valid = 1'b0;
        cyc("c4", 0, 1, 0, 0, 1);
        cyc("c5", 0, 1, 0, 0, 0);

        // Halt with r1 pending; resume and branch ignored until HALTED
        bus.fetch_valid = 1'b1;
        cyc("d0", 0, 1, 0, 0, 0);
        set_dec(NOP, 4'd0, 4'd0, 4'd1, 1'b1);
        cyc("d1", 0, 1, 0, 0, 1);
        set_dec(HALT, 4'd0, 4'd0, 4'd0, 1'b0);
        bus.fetch_valid = 1'b0;
        cyc("d2", 0, 1, 0, 0, 1);
        cyc("d3", 0, 0, 0, 0, 0);
        bus.resume       = 1'b1;
        bus.branch_taken = 1'b1;
        cyc("d4", 0, 0, 0, 0, 0);
        bus.resume       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.wb_valid     = 1'b1;
        bus.wb_dst       = 4'd1;
        cyc("d5", 0, 0, 0, 0, 0);
        bus.wb_valid     = 1'b0;
        bus.branch_taken = 1'b1;
        cyc("d6", 0, 0, 0, 1, 0);
        bus.branch_taken = 1'b0;
        bus.resume       = 1'b1;
        cyc("d7", 0, 0, 0, 1, 0);
        bus.resume = 1'b0;
        cyc("d8", 0, 1, 0, 0, 0);

        // Asynchronous reset while draining with r2 pending
        bus.fetch_valid = 1'b1;
        cyc("e0", 0, 1, 0, 0, 0);
        set_dec(NOP, 4'd0, 4'd0, 4'd2, 1'b1);
        cyc("e1", 0, 1, 0, 0, 1);
        set_dec(HALT, 4'd0, 4'd0, 4'd0, 1'b0);
        bus.fetch_valid = 1'b0;
        cyc("e2", 0, 1, 0, 0, 1);
        check("e.drain_fetch_en", bus.fetch_en, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("e.rst_fetch_en",   bus.fetch_en,   1'b1);
        check("e.rst_decode_en",  bus.decode_en,  1'b1);
        check("e.rst_exec_valid", bus.exec_valid, 1'b0);
        check("e.rst_halted",     bus.halted,     1'b0);
        check("e.rst_stall_cnt",  bus.stall_cnt,  16'h0);
        check("e.rst_flush_cnt",  bus.flush_cnt,  16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_sb();
        set_dec(NOP, 4'd2, 4'd2, 4'd3, 1'b0);
        bus.fetch_valid = 1'b1;
        cyc("e3", 0, 1, 0, 0, 0);
        bus.fetch_valid = 1'b0;
        cyc("e4", 0, 1, 0, 0, 1);
        cyc("e5", 0, 1, 0, 0, 0);

        // Long forced stall for counter saturation, then reset mid-stall
        bus.fetch_valid = 1'b1;
        cyc("g0", 0, 1, 0, 0, 0);
        set_dec(NOP, 4'd0, 4'd0, 4'd7, 1'b1);
        cyc("g1", 0, 1, 0, 0, 1);
        set_dec(NOP, 4'd7, 4'd0, 4'd0, 1'b0);
        bus.fetch_valid = 1'b0;
        cyc("g2", 1, 0, 0, 0, 0);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("g.stall_held", bus.stall,     1'b1);
        check("g.stall_cnt",  bus.stall_cnt, PERF ? 16'hFFFF : 16'h0);
        rst = 1'b1;
        #1;
        check("g.rst_stall",     bus.stall,     1'b0);
        check("g.rst_stall_cnt", bus.stall_cnt, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_sb();
        cyc("g3", 0, 1, 0, 0, 0);
        cyc("g4", 0, 1, 0, 0, 0);
        cyc("g5", 0, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
